// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control: Moore FSM sequencing fetch/decode/execute/mem/wb
// with memory ready handshake, sticky illegal-opcode trap and retire counter.
module multicycle_control #(
   parameter int ALUOP_W = 4,
   parameter int CNT_W   = 32
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic [5:0]         Opcode,
   input  logic               MemReady,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic [1:0]         PCSource,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               MemToReg,
   output logic               RegWrite,
   output logic               RegDst,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic               SignExtend,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               Illegal,
   output logic [3:0]         State,
   output logic [CNT_W-1:0]   InstrCount
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_REXEC  = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_IEXEC  = 4'd10,
      S_IWB    = 4'd11,
      S_TRAP   = 4'd12
   } state_t;

   localparam logic [3:0] A_AND  = 4'b0000;
   localparam logic [3:0] A_OR   = 4'b0001;
   localparam logic [3:0] A_ADD  = 4'b0010;
   localparam logic [3:0] A_SUB  = 4'b0110;
   localparam logic [3:0] A_SLT  = 4'b0111;
   localparam logic [3:0] A_ADDU = 4'b1000;
   localparam logic [3:0] A_XOR  = 4'b1010;
   localparam logic [3:0] A_SLTU = 4'b1011;
   localparam logic [3:0] A_LUI  = 4'b1110;
   localparam logic [3:0] A_FUNC = 4'b1111;

   state_t             r_state;
   logic [5:0]         r_op;
   logic               r_illegal;
   logic [CNT_W-1:0]   r_count;

   state_t             w_next;
   logic               w_retire;
   logic [3:0]         w_alu;
   logic [3:0]         w_ialu;
   logic               w_ise;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_FETCH:  if (MemReady) w_next = S_DECODE;
         S_DECODE: begin
            unique casez (Opcode)
               6'b000000:           w_next = S_REXEC;
               6'b100011, 6'b101011: w_next = S_MEMADR;
               6'b000100:           w_next = S_BRANCH;
               6'b000010:           w_next = S_JUMP;
               6'b001???:           w_next = S_IEXEC;
               default:             w_next = S_TRAP;
            endcase
         end
         S_MEMADR: w_next = (r_op == 6'b100011) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (MemReady) w_next = S_MEMWB;
         S_MEMWB:  w_next = S_FETCH;
         S_MEMWR:  if (MemReady) w_next = S_FETCH;
         S_REXEC:  w_next = S_RWB;
         S_RWB:    w_next = S_FETCH;
         S_BRANCH: w_next = S_FETCH;
         S_JUMP:   w_next = S_FETCH;
         S_IEXEC:  w_next = S_IWB;
         S_IWB:    w_next = S_FETCH;
         default:  w_next = S_TRAP;
      endcase
   end

   // Every path back to FETCH from a non-FETCH state retires one instruction
   assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH);

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state   <= S_FETCH;
         r_op      <= 6'd0;
         r_illegal <= 1'b0;
         r_count   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) r_op <= Opcode;
         if (w_next == S_TRAP) r_illegal <= 1'b1;
         if (w_retire) r_count <= r_count + 1'b1;
      end
   end

   always_comb begin
      w_ialu = A_ADD;
      w_ise  = 1'b0;
      unique case (r_op[2:0])
         3'b000: begin w_ialu = A_ADD;  w_ise = 1'b1; end
         3'b001: begin w_ialu = A_ADDU; w_ise = 1'b0; end
         3'b010: begin w_ialu = A_SLT;  w_ise = 1'b1; end
         3'b011: begin w_ialu = A_SLTU; w_ise = 1'b1; end
         3'b100: begin w_ialu = A_AND;  w_ise = 1'b0; end
         3'b101: begin w_ialu = A_OR;   w_ise = 1'b0; end
         3'b110: begin w_ialu = A_XOR;  w_ise = 1'b0; end
         default: begin w_ialu = A_LUI; w_ise = 1'b0; end
      endcase
   end

   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      PCSource    = 2'b00;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemToReg    = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      SignExtend  = 1'b0;
      w_alu       = 4'b0000;
      unique case (r_state)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            w_alu   = A_ADD;
            IRWrite = MemReady;
            PCWrite = MemReady;
         end
         S_DECODE: begin
            ALUSrcB    = 2'b11;
            w_alu      = A_ADD;
            SignExtend = 1'b1;
         end
         S_MEMADR: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            w_alu      = A_ADD;
            SignExtend = 1'b1;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemToReg = 1'b1;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_REXEC: begin
            ALUSrcA = 1'b1;
            w_alu   = A_FUNC;
         end
         S_RWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            w_alu       = A_SUB;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
         end
         S_IEXEC, S_IWB: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            w_alu      = w_ialu;
            SignExtend = w_ise;
            RegWrite   = (r_state == S_IWB);
         end
         default: ;
      endcase
      // Write enables must not glitch through while reset is held
      if (Reset) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         IRWrite     = 1'b0;
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         RegWrite    = 1'b0;
      end
   end

   assign ALUOp      = ALUOP_W'(w_alu);
   assign Illegal    = r_illegal;
   assign State      = r_state;
   assign InstrCount = r_count;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle MIPS main decoder.
- A Moore FSM sequences each instruction over 3-5 states: fetch, decode, execute, memory and writeback.
- Memory accesses use a ready handshake, so the FSM waits for slow memory.
- Adds a sticky illegal-opcode trap, a debug state output and a retired-instruction counter.
- Drives the shared-memory, single-ALU datapath. The existing ALU control keeps decoding Funct when ALUOp=FUNC.

Parameters:
ALUOP_W  4  width of ALUOp; encodings below occupy the low 4 bits, upper bits are 0
CNT_W  32  width of retired-instruction counter

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high
Opcode  in  6  instruction[31:26] from IR; sampled in DECODE only
MemReady  in  1  memory completes current access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU Zero
PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
IorD  out  1  0 PC address, 1 ALUOut address
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load IR
MemToReg  out  1  register write data from MDR
RegWrite  out  1  register file write
RegDst  out  1  1 rd, 0 rt
ALUSrcA  out  1  0 PC, 1 register A
ALUSrcB  out  2  00 B, 01 const 4, 10 immediate, 11 immediate<<2
SignExtend  out  1  immediate extension mode
ALUOp  out  ALUOP_W  AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, ADDU 1000, XOR 1010, SLTU 1011, LUI 1110, FUNC 1111
Illegal  out  1  sticky unsupported-opcode flag
State  out  4  current state, debug
InstrCount  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (async) → state FETCH, latched opcode 0, Illegal=0, InstrCount=0.
- While Reset is high, these are forced to 0: PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite.
- All other outputs are decoded combinationally from state and the latched opcode. Any output not listed for a state is 0.
- State encodings and per-state outputs:
  FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD; IRWrite=PCWrite=MemReady, PCSource=00. Holds while !MemReady; otherwise → DECODE.
  DECODE(1): latch Opcode; ALUSrcA=0, ALUSrcB=11, ALUOp=ADD, SignExtend=1. Next state by Opcode:
    000000 → REXEC
    100011, 101011 → MEMADR
    000100 → BRANCH
    000010 → JUMP
    001000, 001001, 001010, 001011, 001100, 001101, 001110, 001111 → IEXEC
    any other → TRAP
  MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=ADD, SignExtend=1. → MEMRD for LW, MEMWR for SW.
  MEMRD(3): MemRead=1, IorD=1. Holds until MemReady → MEMWB.
  MEMWB(4): RegWrite=1, MemToReg=1, RegDst=0 → FETCH.
  MEMWR(5): MemWrite=1, IorD=1. Holds until MemReady → FETCH.
  REXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=FUNC → RWB.
  RWB(7): RegWrite=1, RegDst=1 → FETCH.
  BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCWriteCond=1, PCSource=01 → FETCH.
  JUMP(9): PCWrite=1, PCSource=10 → FETCH.
  IEXEC(10): ALUSrcA=1, ALUSrcB=10; ALUOp and SignExtend per latched opcode:
    ADDI: ADD, SignExtend=1
    ADDIU: ADDU, 0
    SLTI: SLT, 1
    SLTIU: SLTU, 1
    ANDI: AND, 0
    ORI: OR, 0
    XORI: XOR, 0
    LUI: LUI, 0
    → IWB.
  IWB(11): RegWrite=1, RegDst=0, MemToReg=0; ALUOp, ALUSrcA, ALUSrcB and SignExtend hold IEXEC values → FETCH.
  TRAP(12): Illegal=1; all enables 0; stays in TRAP until Reset.
- Codes 13-15 are unreachable; if entered → TRAP next cycle.
- InstrCount increments by 1 on each transition into FETCH from MEMWB, MEMWR(ready), RWB, BRANCH, JUMP or IWB.
- Cycle counts per instruction with MemReady tied high:
  LW 5; SW 4; R-type 4; I-type ALU 4; BEQ 3; J 3.
  Each low MemReady cycle adds one cycle.
- Opcode changes outside DECODE have no effect.
- Reset asserted mid-instruction aborts it with no write enable asserted; InstrCount is not incremented.

Test Plan:
- Reset, MemReady=1, Opcode=000000 → states 0,1,6,7,0; RWB has RegWrite=1, RegDst=1; InstrCount=1.
- LW (100011) with MemReady low 2 cycles in FETCH and 3 in MEMRD → FETCH held 3 cycles with IRWrite=0 until the ready cycle; LW completes in 10 cycles; MEMWB has MemToReg=1.
- ORI (001101) then LUI (001111) → IEXEC ALUOp=0001 with SignExtend=0, then ALUOp=1110 with SignExtend=0; IWB keeps those values; InstrCount=2.
- BEQ then J → BRANCH: PCWriteCond=1, PCSource=01, ALUOp=0110; JUMP: PCWrite=1, PCSource=10; each takes 3 cycles.
- Opcode=111111 in DECODE → State=12, Illegal=1, all enables 0 for 20 cycles; Reset → State=0, Illegal=0, InstrCount=0.
- Reset pulsed during MEMWR → MemWrite drops immediately (asynchronous); count unchanged; next fetch starts cleanly. Also preload InstrCount with 2^CNT_W-1 retirements (CNT_W=4: 15 instructions, then one more) → wraps to 0.
